// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register for the OTTER core: captures decoded fields, forwards
// from EX/MEM and MEM/WB into the ALU operands, and bubbles on load-use hazards.
module id_ex_operand_stage #(
   parameter int         XLEN    = 32,
   parameter logic [3:0] NOP_FUN = 4'b0000
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            id_valid,
   input  logic [3:0]      id_alu_fun,
   input  logic [4:0]      id_rs1_addr,
   input  logic [4:0]      id_rs2_addr,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [XLEN-1:0] id_pc,
   input  logic [1:0]      id_srcA_sel,
   input  logic [1:0]      id_srcB_sel,
   input  logic [4:0]      id_rd_addr,
   input  logic            id_reg_write,
   input  logic            id_mem_read,
   input  logic            stall,
   input  logic            flush,
   input  logic            exm_reg_write,
   input  logic [4:0]      exm_rd_addr,
   input  logic [XLEN-1:0] exm_result,
   input  logic            mwb_reg_write,
   input  logic [4:0]      mwb_rd_addr,
   input  logic [XLEN-1:0] mwb_data,
   output logic            load_use_hazard,
   output logic            ex_valid,
   output logic [3:0]      ex_alu_fun,
   output logic [XLEN-1:0] ex_srcA,
   output logic [XLEN-1:0] ex_srcB,
   output logic [XLEN-1:0] ex_store_data,
   output logic [4:0]      ex_rd_addr,
   output logic            ex_reg_write,
   output logic            ex_mem_read
);

   logic [4:0]      rs1_addr_q, rs2_addr_q;
   logic [XLEN-1:0] rs1_data_q, rs2_data_q, imm_q, pc_q;
   logic [1:0]      srcA_sel_q, srcB_sel_q;
   logic [XLEN-1:0] rs1_fwd, rs2_fwd;
   logic            rs1_hit, rs2_hit;

   // rs2 is compared regardless of srcB_sel because stores still need it.
   always_comb begin
      rs1_hit = (ex_rd_addr == id_rs1_addr) && (id_srcA_sel == 2'd0);
      rs2_hit = (ex_rd_addr == id_rs2_addr);
      load_use_hazard = ex_valid && ex_mem_read && (ex_rd_addr != 5'd0) && id_valid
                        && (rs1_hit || rs2_hit) && !stall && !flush;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N || flush || load_use_hazard) begin
         ex_valid     <= 1'b0;
         ex_alu_fun   <= NOP_FUN;
         ex_rd_addr   <= '0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         rs1_addr_q   <= '0;
         rs2_addr_q   <= '0;
         rs1_data_q   <= '0;
         rs2_data_q   <= '0;
         imm_q        <= '0;
         pc_q         <= '0;
         srcA_sel_q   <= '0;
         srcB_sel_q   <= '0;
      end else if (!stall) begin
         ex_valid     <= id_valid;
         ex_alu_fun   <= id_alu_fun;
         ex_rd_addr   <= id_rd_addr;
         ex_reg_write <= id_reg_write & id_valid;
         ex_mem_read  <= id_mem_read & id_valid;
         rs1_addr_q   <= id_rs1_addr;
         rs2_addr_q   <= id_rs2_addr;
         rs1_data_q   <= id_rs1_data;
         rs2_data_q   <= id_rs2_data;
         imm_q        <= id_imm;
         pc_q         <= id_pc;
         srcA_sel_q   <= id_srcA_sel;
         srcB_sel_q   <= id_srcB_sel;
      end
   end

   // EX/MEM is the younger producer, so it wins over MEM/WB; x0 never forwards.
   always_comb begin
      if (exm_reg_write && exm_rd_addr != 5'd0 && exm_rd_addr == rs1_addr_q)
         rs1_fwd = exm_result;
      else if (mwb_reg_write && mwb_rd_addr != 5'd0 && mwb_rd_addr == rs1_addr_q)
         rs1_fwd = mwb_data;
      else
         rs1_fwd = rs1_data_q;

      if (exm_reg_write && exm_rd_addr != 5'd0 && exm_rd_addr == rs2_addr_q)
         rs2_fwd = exm_result;
      else if (mwb_reg_write && mwb_rd_addr != 5'd0 && mwb_rd_addr == rs2_addr_q)
         rs2_fwd = mwb_data;
      else
         rs2_fwd = rs2_data_q;
   end

   always_comb begin
      case (srcA_sel_q)
         2'd0:    ex_srcA = rs1_fwd;
         2'd1:    ex_srcA = pc_q;
         2'd2:    ex_srcA = imm_q;
         default: ex_srcA = '0;
      endcase
      case (srcB_sel_q)
         2'd0:    ex_srcB = rs2_fwd;
         2'd1:    ex_srcB = imm_q;
         2'd2:    ex_srcB = XLEN'(4);
         default: ex_srcB = '0;
      endcase
      ex_store_data = rs2_fwd;
   end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage with hand-computed expected values.
module tb_id_ex_operand_stage;

   localparam int XLEN = 32;

   logic            CLK = 1'b0;
   logic            RST_N;
   logic            id_valid;
   logic [3:0]      id_alu_fun;
   logic [4:0]      id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
   logic [1:0]      id_srcA_sel, id_srcB_sel;
   logic            id_reg_write, id_mem_read, stall, flush;
   logic            exm_reg_write, mwb_reg_write;
   logic [4:0]      exm_rd_addr, mwb_rd_addr;
   logic [XLEN-1:0] exm_result, mwb_data;
   logic            load_use_hazard, ex_valid, ex_reg_write, ex_mem_read;
   logic [3:0]      ex_alu_fun;
   logic [XLEN-1:0] ex_srcA, ex_srcB, ex_store_data;
   logic [4:0]      ex_rd_addr;

   int n_tests = 0;
   int n_fail  = 0;

   id_ex_operand_stage #(.XLEN(XLEN), .NOP_FUN(4'b0000)) dut (
      .CLK(CLK), .RST_N(RST_N), .id_valid(id_valid), .id_alu_fun(id_alu_fun),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_pc(id_pc), .id_srcA_sel(id_srcA_sel), .id_srcB_sel(id_srcB_sel),
      .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .stall(stall), .flush(flush),
      .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
      .mwb_reg_write(mwb_reg_write), .mwb_rd_addr(mwb_rd_addr), .mwb_data(mwb_data),
      .load_use_hazard(load_use_hazard), .ex_valid(ex_valid), .ex_alu_fun(ex_alu_fun),
      .ex_srcA(ex_srcA), .ex_srcB(ex_srcB), .ex_store_data(ex_store_data),
      .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [3:0] fun,
                         input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2,
                         input logic [1:0] sa, input logic [1:0] sb,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic [4:0] rd, input logic rw, input logic mr);
      id_valid = v; id_alu_fun = fun;
      id_rs1_addr = rs1; id_rs1_data = d1; id_rs2_addr = rs2; id_rs2_data = d2;
      id_srcA_sel = sa; id_srcB_sel = sb; id_imm = imm; id_pc = pc;
      id_rd_addr = rd; id_reg_write = rw; id_mem_read = mr;
   endtask

   initial begin
      RST_N = 1'b0; stall = 1'b0; flush = 1'b0;
      exm_reg_write = 1'b0; exm_rd_addr = '0; exm_result = '0;
      mwb_reg_write = 1'b0; mwb_rd_addr = '0; mwb_data = '0;
      set_id(1, 4'd5, 5'd1, 32'h1234, 5'd2, 32'h5678, 2'd1, 2'd1,
             32'h99, 32'h40, 5'd7, 1, 1);

      // Reset held for two edges with a valid instruction presented
      step(); step();
      check("rst_valid", 32'(ex_valid), 32'd0);
      check("rst_regwr", 32'(ex_reg_write), 32'd0);
      check("rst_memrd", 32'(ex_mem_read), 32'd0);
      check("rst_fun", 32'(ex_alu_fun), 32'd0);
      check("rst_srcA", ex_srcA, 32'd0);
      check("rst_srcB", ex_srcB, 32'd0);
      check("rst_store", ex_store_data, 32'd0);
      RST_N = 1'b1;

      // Plain capture, no forwarding matches
      set_id(1, 4'd0, 5'd5, 32'h10, 5'd6, 32'h66, 2'd0, 2'd1,
             32'h20, 32'h0, 5'd9, 1, 0);
      step();
      check("cap_srcA", ex_srcA, 32'h10);
      check("cap_srcB", ex_srcB, 32'h20);
      check("cap_valid", 32'(ex_valid), 32'd1);
      check("cap_rd", 32'(ex_rd_addr), 32'd9);
      check("cap_regwr", 32'(ex_reg_write), 32'd1);
      check("cap_store", ex_store_data, 32'h66);

      // reg_write/mem_read gated by id_valid
      set_id(0, 4'd3, 5'd5, 32'h10, 5'd6, 32'h66, 2'd0, 2'd1,
             32'h20, 32'h0, 5'd9, 1, 1);
      step();
      check("gate_valid", 32'(ex_valid), 32'd0);
      check("gate_regwr", 32'(ex_reg_write), 32'd0);
      check("gate_memrd", 32'(ex_mem_read), 32'd0);

      // Forwarding priority on rs1, then rs2 from MEM/WB
      set_id(1, 4'd0, 5'd7, 32'h1111, 5'd8, 32'h2222, 2'd0, 2'd0,
             32'h0, 32'h0, 5'd10, 1, 0);
      step();
      exm_reg_write = 1; exm_rd_addr = 5'd7; exm_result = 32'hAAAA;
      mwb_reg_write = 1; mwb_rd_addr = 5'd7; mwb_data = 32'hBBBB;
      #1 check("fwd_exm", ex_srcA, 32'hAAAA);
      check("fwd_rs2_none", ex_srcB, 32'h2222);
      exm_reg_write = 0;
      #1 check("fwd_mwb", ex_srcA, 32'hBBBB);
      mwb_reg_write = 0;
      #1 check("fwd_none", ex_srcA, 32'h1111);
      mwb_reg_write = 1; mwb_rd_addr = 5'd8;
      #1 check("fwd_rs2_srcB", ex_srcB, 32'hBBBB);
      check("fwd_rs2_store", ex_store_data, 32'hBBBB);
      check("fwd_rs1_clear", ex_srcA, 32'h1111);

      // x0 never forwards
      set_id(1, 4'd0, 5'd0, 32'h55, 5'd0, 32'h77, 2'd0, 2'd0,
             32'h0, 32'h0, 5'd11, 1, 0);
      exm_reg_write = 1; exm_rd_addr = 5'd0; exm_result = 32'hDEAD;
      mwb_reg_write = 1; mwb_rd_addr = 5'd0; mwb_data = 32'hBEEF;
      step();
      check("x0_srcA", ex_srcA, 32'h55);
      check("x0_srcB", ex_srcB, 32'h77);
      exm_reg_write = 0; mwb_reg_write = 0;

      // Load-use hazard on rs2 (srcB selects imm, still a hazard)
      set_id(1, 4'd0, 5'd1, 32'h1, 5'd2, 32'h2, 2'd0, 2'd0,
             32'h0, 32'h0, 5'd3, 1, 1);
      step();
      check("ld_memrd", 32'(ex_mem_read), 32'd1);
      set_id(1, 4'd2, 5'd10, 32'hA0, 5'd3, 32'h30, 2'd0, 2'd1,
             32'h8, 32'h0, 5'd4, 1, 0);
      #1 check("lu_hazard", 32'(load_use_hazard), 32'd1);
      stall = 1;
      #1 check("lu_masked_stall", 32'(load_use_hazard), 32'd0);
      stall = 0; flush = 1;
      #1 check("lu_masked_flush", 32'(load_use_hazard), 32'd0);
      flush = 0;
      step();
      check("lu_bubble_valid", 32'(ex_valid), 32'd0);
      check("lu_bubble_regwr", 32'(ex_reg_write), 32'd0);
      check("lu_bubble_rd", 32'(ex_rd_addr), 32'd0);
      check("lu_clear", 32'(load_use_hazard), 32'd0);
      step();
      check("lu_reissue_valid", 32'(ex_valid), 32'd1);
      check("lu_reissue_rd", 32'(ex_rd_addr), 32'd4);
      check("lu_reissue_fun", 32'(ex_alu_fun), 32'd2);

      // rs1 match with srcA_sel=pc: no hazard
      set_id(1, 4'd0, 5'd1, 32'h1, 5'd2, 32'h2, 2'd0, 2'd0,
             32'h0, 32'h0, 5'd3, 1, 1);
      step();
      set_id(1, 4'd0, 5'd3, 32'h0, 5'd9, 32'h0, 2'd1, 2'd1,
             32'h0, 32'h0, 5'd4, 1, 0);
      #1 check("lu_rs1_pcsel", 32'(load_use_hazard), 32'd0);
      id_srcA_sel = 2'd0;
      #1 check("lu_rs1_hit", 32'(load_use_hazard), 32'd1);

      // Stall holds for 3 edges, then flush+stall kills
      set_id(1, 4'd6, 5'd12, 32'h600, 5'd13, 32'h700, 2'd0, 2'd0,
             32'h0, 32'h0, 5'd14, 1, 0);
      step();
      set_id(1, 4'd9, 5'd1, 32'h1, 5'd2, 32'h2, 2'd3, 2'd3,
             32'h0, 32'h0, 5'd15, 1, 1);
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_rd", 32'(ex_rd_addr), 32'd14);
         check("stall_srcA", ex_srcA, 32'h600);
      end
      check("stall_fun", 32'(ex_alu_fun), 32'd6);
      check("stall_valid", 32'(ex_valid), 32'd1);
      flush = 1;
      step();
      check("flush_valid", 32'(ex_valid), 32'd0);
      check("flush_rd", 32'(ex_rd_addr), 32'd0);
      check("flush_fun", 32'(ex_alu_fun), 32'd0);
      flush = 0; stall = 0;

      // Reset during stall clears the stage
      set_id(1, 4'd6, 5'd12, 32'h600, 5'd13, 32'h700, 2'd0, 2'd0,
             32'h0, 32'h0, 5'd14, 1, 0);
      step();
      stall = 1; RST_N = 0;
      step();
      check("rst_stall_valid", 32'(ex_valid), 32'd0);
      check("rst_stall_srcA", ex_srcA, 32'd0);
      stall = 0; RST_N = 1;

      // lui / auipc-style operand selects
      set_id(1, 4'd7, 5'd1, 32'h1, 5'd2, 32'h2, 2'd2, 2'd3,
             32'h12345000, 32'h0, 5'd5, 1, 0);
      step();
      check("lui_srcA", ex_srcA, 32'h12345000);
      check("lui_srcB", ex_srcB, 32'd0);
      check("lui_fun", 32'(ex_alu_fun), 32'd7);
      set_id(1, 4'd0, 5'd1, 32'h1, 5'd2, 32'h2, 2'd1, 2'd2,
             32'h0, 32'h100, 5'd1, 1, 0);
      step();
      check("jal_srcA", ex_srcA, 32'h100);
      check("jal_srcB", ex_srcB, 32'd4);
      check("jal_store", ex_store_data, 32'h2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register for the pipelined OTTER core; the producer end of the ALU operand interface.
- Captures decoded fields each cycle and drives alu_fun, srcA and srcB into the execute-stage ALU.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts bubbles; supports downstream stall and branch flush.

Parameters:
- XLEN, 32, datapath width of operands and results.
- NOP_FUN, 4'b0000, alu_fun value loaded on bubble or reset (add).

Ports:
- CLK  in  1  core clock
- RST_N  in  1  synchronous active-low reset
- id_valid  in  1  decode stage holds a real instruction
- id_alu_fun  in  4  ALU function code from decoder
- id_rs1_addr  in  5  source register 1 index
- id_rs2_addr  in  5  source register 2 index
- id_rs1_data  in  XLEN  register file read port 1
- id_rs2_data  in  XLEN  register file read port 2
- id_imm  in  XLEN  sign-extended immediate
- id_pc  in  XLEN  instruction PC
- id_srcA_sel  in  2  0=rs1, 1=pc, 2=imm (lui), 3=zero
- id_srcB_sel  in  2  0=rs2, 1=imm, 2=const 4, 3=zero
- id_rd_addr  in  5  destination register
- id_reg_write  in  1  instruction writes rd
- id_mem_read  in  1  instruction is a load
- stall  in  1  downstream stall: hold stage contents
- flush  in  1  branch/jump taken: kill stage contents
- exm_reg_write  in  1  EX/MEM instruction writes rd
- exm_rd_addr  in  5  EX/MEM rd
- exm_result  in  XLEN  EX/MEM ALU result
- mwb_reg_write  in  1  MEM/WB instruction writes rd
- mwb_rd_addr  in  5  MEM/WB rd
- mwb_data  in  XLEN  MEM/WB writeback value
- load_use_hazard  out  1  ID must hold; combinational
- ex_valid  out  1  EX holds a real instruction
- ex_alu_fun  out  4  to ALU alu_fun
- ex_srcA  out  XLEN  to ALU srcA, after forwarding
- ex_srcB  out  XLEN  to ALU srcB, after forwarding
- ex_store_data  out  XLEN  forwarded rs2 value, for stores
- ex_rd_addr  out  5  registered rd
- ex_reg_write  out  1  registered reg_write, gated by valid
- ex_mem_read  out  1  registered mem_read, gated by valid

Behaviour:
- Clocking and reset: single clock CLK; all state updates on the rising edge. Reset is synchronous, active-low on RST_N.
- Reset (RST_N=0 at the edge): ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_alu_fun=NOP_FUN, ex_rd_addr=0, all stored data/addr/sel fields=0. With these values ex_srcA, ex_srcB and ex_store_data read 0. Reset overrides flush and stall.
- Per-edge update priority:
  - flush: bubble is loaded.
  - else stall: all registers hold.
  - else load_use_hazard: bubble is loaded; upstream holds ID.
  - else capture all id_* fields; valid=id_valid.
- Bubble: valid=0, reg_write=0, mem_read=0, alu_fun=NOP_FUN, rd=0. Operand fields are don't-care but are driven to 0.
- Gating: stored reg_write and mem_read are ANDed with id_valid on capture.
- load_use_hazard = ex_valid & ex_mem_read & (ex_rd_addr!=0) & id_valid & ((ex_rd_addr==id_rs1_addr & id_srcA_sel==0) | (ex_rd_addr==id_rs2_addr)).
  - rs2 is checked regardless of srcB_sel, because of store data.
  - Forced 0 while stall=1 or flush=1.
- Forwarding is combinational on the registered rs1/rs2 and raw data, applied to each of rs1 and rs2 independently:
  - EX/MEM match (reg_write, rd!=0, rd==rs) has highest priority.
  - MEM/WB match is next.
  - Otherwise the registered register-file value is used.
  - rd==0 never forwards.
- ex_srcA mux by the stored srcA_sel: forwarded rs1 / pc / imm / 0. ex_srcB mux by the stored srcB_sel: forwarded rs2 / imm / 32'd4 / 0.
- ex_store_data = forwarded rs2, always.
- Latency: one cycle, ID fields to EX outputs. Forwarding adds no cycle.
- Simultaneous events:
  - flush+stall: flush wins.
  - Hazard during stall: no bubble, hold.
  - Reset mid-stall: the stage clears.

Test Plan:
- Reset: RST_N=0 for 2 edges with id_valid=1 -> ex_valid=0, ex_reg_write=0, ex_alu_fun=0, ex_srcA=ex_srcB=0.
- Plain capture: rs1=5 data 0x10, imm=0x20, srcB_sel=1, alu_fun=0, no matches -> next cycle ex_srcA=0x10, ex_srcB=0x20, ex_valid=1.
- Forward priority: rs1=7; exm rd=7 result 0xAAAA; mwb rd=7 data 0xBBBB, both writing -> ex_srcA=0xAAAA. Drop exm_reg_write -> 0xBBBB. rs1=0 with rd=0 matches -> register-file value.
- Load-use: EX holds a load with rd=3, ID rs2=3 -> load_use_hazard=1. Next edge ex_valid=0, ex_reg_write=0. Hazard then clears.
- Stall/flush: valid instruction in EX, stall=1 for 3 edges -> outputs unchanged. Then flush=1 with stall=1 -> ex_valid=0 after the edge.
- lui/auipc/jal selects: srcA_sel=2 imm 0x12345000 -> ex_srcA=0x12345000. srcA_sel=1 pc 0x100 with srcB_sel=2 -> ex_srcA=0x100, ex_srcB=4.
